// File: rtl/router_pkt_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_tx_pkg
//  Purpose  : Shared types and constants for the router packet transmitter:
//             FSM state codes, header layout, command legality helper.
//  Revision : 1.0  initial release
// ============================================================================
package router_pkt_tx_pkg;

    // Symbolic view of the transmitter states (used for readability/debug)
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        GAP     = 3'd4
    } tx_state_e;

    // Plain constant encodings used by the FSM register
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    // Header byte as seen by the router: length in the upper six bits
    typedef struct packed {
        logic [5:0] len;
        logic [1:0] addr;
    } pkt_hdr_t;

    // Destination 3 does not exist on the router
    localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

    // A command is legal when it targets a real port and carries payload
    function automatic logic cmd_is_legal(input logic [1:0] addr,
                                          input logic [5:0] len);
        return (addr != ADDR_ILLEGAL) && (len != 6'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_tx_if
//  Purpose  : Command, payload staging and router-side signals of the packet
//             transmitter. slave = transmitter view, master = driver view.
//             ROUTER_TX_ERR_INJ_EN adds the inj_err command qualifier.
//  Revision : 1.0  initial release
// ============================================================================
interface router_pkt_tx_if;

    // command channel
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
`ifdef ROUTER_TX_ERR_INJ_EN
    logic       inj_err;
`endif

    // payload staging channel
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;

    // router side
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;

    // status
    logic       pkt_done;
    logic       cmd_err;
    logic       tx_active;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
`ifdef ROUTER_TX_ERR_INJ_EN
        input  inj_err,
`endif
        input  pl_valid, pl_data, busy,
        output cmd_ready, pl_ready, pkt_valid, data_out,
        output pkt_done, cmd_err, tx_active
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len,
`ifdef ROUTER_TX_ERR_INJ_EN
        output inj_err,
`endif
        output pl_valid, pl_data, busy,
        input  cmd_ready, pl_ready, pkt_valid, data_out,
        input  pkt_done, cmd_err, tx_active
    );

endinterface
`default_nettype wire

// File: rtl/router_pkt_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : router_tx_fifo
//  Purpose  : 8-bit synchronous payload staging FIFO with occupancy count.
//             Writes when full and reads when empty are ignored. Head data
//             is presented combinationally (show-ahead).
//  Revision : 1.0  initial release
// ============================================================================
module router_tx_fifo #(
    parameter int DEPTH = 64
) (
    input  wire logic                       clock,
    input  wire logic                       resetn,
    input  wire logic                       push_i,
    input  wire logic [7:0]                 data_i,
    input  wire logic                       pop_i,
    output logic      [7:0]                 data_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic      [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          w_push, w_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i  && !empty_o;

    // Storage array: no reset needed, validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_tx
//  Purpose  : Router-side packet transmitter. Takes a {len,addr} command,
//             sends header, len payload bytes from the staging FIFO and an
//             even-XOR parity byte, then idles for GAP_CYCLES.
//             Optional macro ROUTER_TX_ERR_INJ_EN adds inj_err, which makes
//             the packet carry an inverted parity byte.
//  Revision : 1.0  initial release
// ============================================================================
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int GAP_CYCLES = 2
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    router_pkt_tx_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // FSM and output registers
    logic [2:0]    state_q,     state_d;
    logic [7:0]    data_out_q,  data_out_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic [7:0]    parity_q,    parity_d;
    logic [5:0]    cnt_q,       cnt_d;
    logic [GW-1:0] gap_q,       gap_d;
    logic          pkt_done_q,  pkt_done_d;
    logic          cmd_err_q,   cmd_err_d;

    // FIFO interface
    logic [7:0]    w_fifo_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_pop_req;
    logic          w_fifo_pop;

    // command decode
    logic          w_cmd_ready;
    logic          w_cmd_fire;
    logic          w_cmd_legal;
    pkt_hdr_t      w_hdr;
    logic [7:0]    w_parity_out;

    router_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (bus.pl_valid),
        .data_i  (bus.pl_data),
        .pop_i   (w_fifo_pop),
        .data_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Only take a command once its whole payload is staged, so the payload
    // stream never starves mid-packet
    assign w_cmd_ready = (state_q == ST_IDLE) && (w_fifo_count >= CW'(bus.cmd_len));
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    assign w_cmd_legal = cmd_is_legal(bus.cmd_addr, bus.cmd_len);
    assign w_fifo_pop  = w_pop_req && !w_fifo_empty;

    always_comb begin
        w_hdr.len  = bus.cmd_len;
        w_hdr.addr = bus.cmd_addr;
    end

`ifdef ROUTER_TX_ERR_INJ_EN
    logic inj_q, inj_d;

    // Error-injection flag is captured with the command and held for the packet
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end

    // Capture inj_err only on a legal command accept
    always_comb begin
        inj_d = inj_q;
        if ((state_q == ST_IDLE) && w_cmd_fire && w_cmd_legal) begin
            inj_d = bus.inj_err;
        end
    end

    assign w_parity_out = parity_q ^ {8{inj_q}};
`else
    assign w_parity_out = parity_q;
`endif

    // Next-state logic: every transfer state advances only when busy is low;
    // the gap state runs on its own timer regardless of busy
    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        pkt_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        w_pop_req   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if (w_cmd_legal) begin
                        state_d     = ST_HEADER;
                        data_out_d  = w_hdr;
                        pkt_valid_d = 1'b1;
                        parity_d    = w_hdr;
                        cnt_d       = bus.cmd_len;
                    end else begin
                        cmd_err_d   = 1'b1;
                    end
                end
            end

            ST_HEADER: begin
                if (!bus.busy) begin
                    w_pop_req  = 1'b1;
                    data_out_d = w_fifo_head;
                    parity_d   = parity_q ^ w_fifo_head;
                    state_d    = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                // cnt_q is the number of payload bytes not yet transferred,
                // including the one currently on the bus
                if (!bus.busy) begin
                    if (cnt_q == 6'd1) begin
                        state_d     = ST_PARITY;
                        pkt_valid_d = 1'b0;
                        data_out_d  = w_parity_out;
                    end else begin
                        w_pop_req   = 1'b1;
                        data_out_d  = w_fifo_head;
                        parity_d    = parity_q ^ w_fifo_head;
                        cnt_d       = cnt_q - 6'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (!bus.busy) begin
                    pkt_done_d = 1'b1;
                    data_out_d = 8'h00;
                    gap_d      = GW'(GAP_CYCLES - 1);
                    state_d    = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q - 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                data_out_d  = 8'h00;
                pkt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            data_out_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            parity_q    <= 8'h00;
            cnt_q       <= 6'd0;
            gap_q       <= '0;
            pkt_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            parity_q    <= parity_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            pkt_done_q  <= pkt_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.pl_ready  = !w_fifo_full;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.tx_active = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_pkt_tx
//  Purpose  : Self-checking bench for router_pkt_tx. A queue holds the staged
//             payload; each packet's expected byte stream (header, payload,
//             parity) is built from that queue when the command is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_pkt_tx;

    localparam int DEPTH = 64;
    localparam int GAP   = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    router_pkt_tx_if tif ();

    router_pkt_tx #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (tif)
    );

    logic [7:0] mq[$];      // bytes staged in the FIFO, oldest first
    int         pending;    // bytes of the current packet not yet popped
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_par;
    int         hold_seen;
    bit         saw_full;

    task automatic drive_idle();
        tif.cmd_valid = 1'b0;
        tif.cmd_addr  = 2'd0;
        tif.cmd_len   = 6'd0;
        tif.pl_valid  = 1'b0;
        tif.pl_data   = 8'h00;
        tif.busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
        tif.inj_err   = 1'b0;
`endif
    endtask

    // Randomly write a payload byte; the model keeps it only if there is room
    task automatic set_push(input int pct);
        logic [7:0] d;
        if (int'($urandom_range(99)) < pct) begin
            d = 8'($urandom);
            tif.pl_valid = 1'b1;
            tif.pl_data  = d;
            if (mq.size() + pending < DEPTH) mq.push_back(d);
        end else begin
            tif.pl_valid = 1'b0;
        end
    endtask

    task automatic push_list(input logic [7:0] bl[$]);
        foreach (bl[i]) begin
            @(negedge clock);
            tif.cmd_valid = 1'b0;
            tif.busy      = 1'b0;
            tif.pl_valid  = 1'b1;
            tif.pl_data   = bl[i];
            if (mq.size() + pending < DEPTH) mq.push_back(bl[i]);
        end
        @(negedge clock);
        tif.pl_valid = 1'b0;
    endtask

    // Issue a command, follow the whole packet and the gap that follows it
    task automatic run_packet(input logic [1:0] addr, input logic [5:0] len,
                              input int busy_pct, input int push_pct, input bit inj,
                              input int hold_k, input int hold_n);
        logic [7:0] exp[$];
        logic [7:0] par;
        logic [7:0] b8;
        bit         acc, exp_rdy, b;
        int         cyc, k, held;
        acc = 1'b0;
        cyc = 0;
        hold_seen = 0;
        while (!acc && cyc < 300) begin
            @(negedge clock);
            exp_rdy = (mq.size() >= int'(len));
            tif.cmd_valid = 1'b1;
            tif.cmd_addr  = addr;
            tif.cmd_len   = len;
            tif.busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
            tif.inj_err   = inj;
`endif
            set_push(push_pct);
            #1;
            n_cmp++;
            if (tif.cmd_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL cmd_ready: got %b expected %b (staged %0d len %0d)",
                         tif.cmd_ready, exp_rdy, mq.size(), len);
            end
            acc = tif.cmd_ready;
            cyc++;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept_timeout: got no accept expected accept");
            tif.cmd_valid = 1'b0;
            return;
        end
        // Expected stream: header, len oldest staged bytes, parity
        par = {len, addr};
        exp.push_back(par);
        for (int i = 0; i < int'(len); i++) begin
            b8 = (mq.size() > 0) ? mq.pop_front() : 8'h00;
            exp.push_back(b8);
            par = par ^ b8;
        end
        if (inj) par = ~par;
        exp.push_back(par);
        pending = int'(len);

        k = 0; held = 0; cyc = 0;
        while (k < int'(len) + 2 && cyc < 2000) begin
            @(negedge clock);
            tif.cmd_valid = 1'b0;
            n_cmp++;
            if (tif.pkt_valid !== (k <= int'(len)) || tif.data_out !== exp[k]) begin
                n_err++;
                $display("FAIL pkt_byte[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                         k, tif.pkt_valid, tif.data_out, (k <= int'(len)), exp[k]);
            end
            n_cmp++;
            if (tif.tx_active !== 1'b1 || tif.cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_status: got tx_active=%b cmd_ready=%b expected 1 0",
                         tif.tx_active, tif.cmd_ready);
            end
            n_cmp++;
            if (tif.pl_ready !== (mq.size() + pending < DEPTH)) begin
                n_err++;
                $display("FAIL pl_ready: got %b expected %b", tif.pl_ready,
                         (mq.size() + pending < DEPTH));
            end
            if (tif.pl_ready === 1'b0) saw_full = 1'b1;
            if (k == hold_k && tif.data_out === exp[k]) hold_seen++;
            if (k == hold_k && held < hold_n) begin
                b = 1'b1;
                held++;
            end else begin
                b = (int'($urandom_range(99)) < busy_pct);
            end
            tif.busy = b;
            set_push(push_pct);
            if (!b) begin
                if (k < int'(len)) pending--;
                if (k == int'(len) + 1) last_par = tif.data_out;
                k++;
            end
            cyc++;
        end
        if (k < int'(len) + 2) begin
            n_cmp++; n_err++;
            $display("FAIL packet_timeout: got %0d transfers expected %0d", k, len + 2);
        end
        pending = 0;
        for (int g = 1; g <= GAP + 1; g++) begin
            @(negedge clock);
            n_cmp++;
            if (tif.pkt_done !== (g == 1) || tif.pkt_valid !== 1'b0 ||
                tif.data_out !== 8'h00 || tif.tx_active !== (g <= GAP)) begin
                n_err++;
                $display("FAIL gap[%0d]: got done=%b valid=%b data=%h active=%b expected done=%b valid=0 data=00 active=%b",
                         g, tif.pkt_done, tif.pkt_valid, tif.data_out, tif.tx_active,
                         (g == 1), (g <= GAP));
            end
            tif.busy = 1'($urandom);
            set_push(push_pct);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        mq.delete();
        pending = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (tif.pkt_valid !== 1'b0 || tif.data_out !== 8'h00 || tif.pkt_done !== 1'b0 ||
            tif.cmd_err !== 1'b0 || tif.tx_active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h done=%b err=%b active=%b expected all 0",
                     tif.pkt_valid, tif.data_out, tif.pkt_done, tif.cmd_err, tif.tx_active);
        end
        n_cmp++;
        if (tif.pl_ready !== 1'b1 || tif.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got pl_ready=%b cmd_ready=%b expected 1 1",
                     tif.pl_ready, tif.cmd_ready);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [7:0] bl[$];
        bl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push_list(bl);
        run_packet(2'd1, 6'd5, 0, 0, 1'b0, -1, 0);
        n_cmp++;
        if (last_par !== 8'h04) begin
            n_err++;
            $display("FAIL basic_parity: got %h expected 04", last_par);
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] bl[$];
        bl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push_list(bl);
        run_packet(2'd1, 6'd5, 0, 0, 1'b0, 2, 3);
        n_cmp++;
        if (hold_seen !== 4) begin
            n_err++;
            $display("FAIL busy_hold_cycles: got %0d expected 4", hold_seen);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] bl[$];
        logic [1:0] ad[2];
        logic [5:0] ln[2];
        bl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        push_list(bl);
        ad[0] = 2'd3; ln[0] = 6'd4;
        ad[1] = 2'd1; ln[1] = 6'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            tif.cmd_valid = 1'b1;
            tif.cmd_addr  = ad[i];
            tif.cmd_len   = ln[i];
            tif.pl_valid  = 1'b0;
            #1;
            n_cmp++;
            if (tif.cmd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL illegal_ready[%0d]: got %b expected 1", i, tif.cmd_ready);
            end
            @(negedge clock);
            tif.cmd_valid = 1'b0;
            n_cmp++;
            if (tif.cmd_err !== 1'b1 || tif.pkt_valid !== 1'b0 || tif.tx_active !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_err[%0d]: got err=%b valid=%b active=%b expected 1 0 0",
                         i, tif.cmd_err, tif.pkt_valid, tif.tx_active);
            end
            @(negedge clock);
            n_cmp++;
            if (tif.cmd_err !== 1'b0 || tif.pkt_valid !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_pulse[%0d]: got err=%b valid=%b expected 0 0",
                         i, tif.cmd_err, tif.pkt_valid);
            end
        end
        // Staged bytes must still be there, in order
        run_packet(2'd2, 6'd4, 0, 0, 1'b0, -1, 0);
    endtask

    task automatic test_wait_len();
        logic [7:0] bl[$];
        bl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_list(bl);
        run_packet(2'd0, 6'd10, 0, 100, 1'b0, -1, 0);
    endtask

    task automatic test_fill();
        while (mq.size() < 63) begin
            @(negedge clock);
            drive_idle();
            set_push(100);
        end
        saw_full = 1'b0;
        run_packet(2'd0, 6'd63, 20, 100, 1'b0, -1, 0);
        n_cmp++;
        if (saw_full !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full_seen: got %b expected 1", saw_full);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            run_packet(2'($urandom_range(2)), 6'($urandom_range(63, 1)),
                       30, 70, 1'b0, -1, 0);
        end
    endtask

    task automatic test_reset_mid();
        while (mq.size() < 8) begin
            @(negedge clock);
            drive_idle();
            set_push(100);
        end
        @(negedge clock);
        tif.pl_valid  = 1'b0;
        tif.cmd_valid = 1'b1;
        tif.cmd_addr  = 2'd2;
        tif.cmd_len   = 6'd8;
        tif.busy      = 1'b0;
        repeat (3) @(negedge clock);
        tif.cmd_valid = 1'b0;
        n_cmp++;
        if (tif.pkt_valid !== 1'b1 || tif.tx_active !== 1'b1) begin
            n_err++;
            $display("FAIL mid_packet_active: got valid=%b active=%b expected 1 1",
                     tif.pkt_valid, tif.tx_active);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (tif.pkt_valid !== 1'b0 || tif.data_out !== 8'h00 || tif.tx_active !== 1'b0 ||
            tif.pl_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b data=%h active=%b pl_ready=%b expected 0 00 0 1",
                     tif.pkt_valid, tif.data_out, tif.tx_active, tif.pl_ready);
        end
        mq.delete();
        pending = 0;
        @(negedge clock);
        resetn = 1'b1;
        // FIFO is empty: the command must wait for three fresh bytes
        run_packet(2'd1, 6'd3, 10, 100, 1'b0, -1, 0);
    endtask

`ifdef ROUTER_TX_ERR_INJ_EN
    task automatic test_inj();
        logic [7:0] bl[$];
        test_reset();
        bl = '{8'hA5};
        push_list(bl);
        run_packet(2'd0, 6'd1, 0, 0, 1'b1, -1, 0);
        n_cmp++;
        if (last_par !== 8'h5E) begin
            n_err++;
            $display("FAIL inj_parity: got %h expected 5e", last_par);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pending  = 0;
        saw_full = 1'b0;
        last_par = 8'h00;
        test_reset();
        test_basic();
        test_busy_hold();
        test_illegal();
        test_wait_len();
        test_fill();
        test_random();
        test_reset_mid();
`ifdef ROUTER_TX_ERR_INJ_EN
        test_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
